// File: rtl/ysyx_220066_mem_pkg.sv
// Shared memory-access helpers: size encodings, byte-lane masks, data replication
// and alignment checks. The load path and the store buffer both use these.
package ysyx_220066_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size_e'(size))
      SZ_B:    m = 8'h01 << off;
      SZ_H:    m = 8'h03 << off;
      SZ_W:    m = 8'h0F << off;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] size_rep_data(input logic [1:0] size, input logic [63:0] d);
    logic [63:0] r;
    case (size_e'(size))
      SZ_B:    r = {8{d[7:0]}};
      SZ_H:    r = {4{d[15:0]}};
      SZ_W:    r = {2{d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic size_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size_e'(size))
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_220066_st_fmt.sv
// Store formatter: turns a raw store into an 8-byte-aligned address,
// lane-replicated data and a byte mask, and flags misaligned accesses.
module ysyx_220066_st_fmt
  import ysyx_220066_mem_pkg::*;
(
  input  logic [63:0] addr,
  input  logic [1:0]  size,
  input  logic [63:0] data,
  output logic [63:0] aligned_addr,
  output logic [7:0]  mask,
  output logic [63:0] wdata,
  output logic        misalign
);

  assign aligned_addr = {addr[63:3], 3'b000};
  assign mask         = size_mask(size, addr[2:0]);
  assign wdata        = size_rep_data(size, data);
  assign misalign     = size_misaligned(size, addr[2:0]);

endmodule

// File: rtl/ysyx_220066_store_buf.sv
// MEM-stage store buffer: formats and queues stores, drains them through a
// valid/ready write port, and flags loads that hit a pending 8-byte word.
module ysyx_220066_store_buf
  import ysyx_220066_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [63:0] st_addr,
  input  logic [63:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_misalign,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        ld_valid,
  input  logic [63:0] ld_addr,
  output logic        ld_hit,
  output logic        empty
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [63:0]      ent_addr [DEPTH];
  logic [63:0]      ent_data [DEPTH];
  logic [7:0]       ent_mask [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;

  logic [63:0] fmt_addr, fmt_data;
  logic [7:0]  fmt_mask;
  logic        fmt_mis;
  logic        accept, push, pop, hit_any;

  ysyx_220066_st_fmt u_fmt (
    .addr         (st_addr),
    .size         (st_size),
    .data         (st_data),
    .aligned_addr (fmt_addr),
    .mask         (fmt_mask),
    .wdata        (fmt_data),
    .misalign     (fmt_mis)
  );

  assign st_ready   = (count != CNT_FULL);
  assign mem_wvalid = (count != '0);
  assign empty      = (count == '0);

  assign accept = st_valid && st_ready;
  assign push   = accept && !fmt_mis;
  assign pop    = mem_wvalid && mem_wready;

  assign mem_waddr = ent_addr[rd_ptr];
  assign mem_wdata = ent_data[rd_ptr];
  assign mem_wmask = ent_mask[rd_ptr];

  // Stored addresses have zero low bits, so masking the XOR gives a word compare.
  always_comb begin
    hit_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (((ent_addr[i] ^ ld_addr) & ~64'h7) == 64'h0)) hit_any = 1'b1;
    end
  end

  assign ld_hit = ld_valid && hit_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      st_misalign <= 1'b0;
      ent_vld     <= '0;
    end else begin
      st_misalign <= accept && fmt_mis;
      if (pop) begin
        rd_ptr          <= rd_ptr + PTR_ONE;
        ent_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr          <= wr_ptr + PTR_ONE;
        ent_vld[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; the valid bits and count gate its use.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= fmt_addr;
      ent_data[wr_ptr] <= fmt_data;
      ent_mask[wr_ptr] <= fmt_mask;
    end
  end

endmodule

// File: tb/tb_ysyx_220066_store_buf.sv
// Self-checking bench for the store buffer: directed vector table, multi-cycle
// corner sequences and randomized traffic against a queue-based reference model.
module tb_ysyx_220066_store_buf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready, st_misalign;
  logic [63:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        mem_wvalid, mem_wready;
  logic [63:0] mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        ld_valid, ld_hit, empty;
  logic [63:0] ld_addr;

  always #5 clk = ~clk;

  ysyx_220066_store_buf #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_size     (st_size),
    .st_misalign (st_misalign),
    .mem_wvalid  (mem_wvalid),
    .mem_wready  (mem_wready),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_hit      (ld_hit),
    .empty       (empty)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } ent_t;

  ent_t q[$];
  bit   mis_q = 1'b0;

  typedef struct {
    logic        sv;
    logic [63:0] sa;
    logic [63:0] sd;
    logic [1:0]  ss;
    logic        wr;
    logic        lv;
    logic [63:0] la;
    logic        rdy, wv, hit, mis, emp;
    logic [63:0] waddr, wdata;
    logic [7:0]  wmask;
  } vec_t;

  vec_t tbl[19];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference formatting from first principles: n-byte access, n-bit mask at the byte offset,
  // each output byte lane b takes source byte (b mod n).
  function automatic ent_t ref_fmt(input logic [63:0] a, input logic [63:0] d,
                                   input logic [1:0] sz, output bit mis);
    ent_t e;
    int n, off, m;
    n      = 1 << sz;
    off    = int'(a % 8);
    mis    = (a % n) != 0;
    e.addr = a - (a % 8);
    m      = ((1 << n) - 1) << off;
    e.mask = m[7:0];
    for (int b = 0; b < 8; b++) e.data[8*b +: 8] = d[8*(b % n) +: 8];
    return e;
  endfunction

  task automatic drive(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                       input logic [1:0] ss, input logic wr, input logic lv, input logic [63:0] la);
    st_valid   = sv;
    st_addr    = sa;
    st_data    = sd;
    st_size    = ss;
    mem_wready = wr;
    ld_valid   = lv;
    ld_addr    = la;
  endtask

  // One clock of stimulus, checked against the model before the edge, model advanced after it.
  task automatic mcycle(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                        input logic [1:0] ss, input logic wr, input logic lv, input logic [63:0] la);
    ent_t e;
    bit   mis, hit, acc, pp;
    drive(sv, sa, sd, ss, wr, lv, la);
    #1;
    chk1("st_ready", st_ready, q.size() != DEPTH);
    chk1("mem_wvalid", mem_wvalid, q.size() != 0);
    chk1("empty", empty, q.size() == 0);
    chk1("st_misalign", st_misalign, mis_q);
    hit = 1'b0;
    foreach (q[i]) if (q[i].addr / 8 == la / 8) hit = 1'b1;
    chk1("ld_hit", ld_hit, hit && lv);
    if (q.size() != 0) begin
      chk64("head_addr", mem_waddr, q[0].addr);
      chk64("head_data", mem_wdata, q[0].data);
      chk64("head_mask", {56'h0, mem_wmask}, {56'h0, q[0].mask});
    end
    acc = sv && (q.size() != DEPTH);
    pp  = wr && (q.size() != 0);
    e   = ref_fmt(sa, sd, ss, mis);
    @(posedge clk);
    #1;
    if (pp) void'(q.pop_front());
    if (acc && !mis) q.push_back(e);
    mis_q = acc && mis;
  endtask

  function automatic vec_t vec(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                               input logic [1:0] ss, input logic wr, input logic lv,
                               input logic [63:0] la, input logic rdy, input logic wv,
                               input logic hit, input logic mis, input logic emp,
                               input logic [63:0] waddr, input logic [63:0] wdata,
                               input logic [7:0] wmask);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.ss = ss; v.wr = wr; v.lv = lv; v.la = la;
    v.rdy = rdy; v.wv = wv; v.hit = hit; v.mis = mis; v.emp = emp;
    v.waddr = waddr; v.wdata = wdata; v.wmask = wmask;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_wvalid", mem_wvalid, 1'b0);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_ready", st_ready, 1'b1);
    chk1("rst_ldhit", ld_hit, 1'b0);
    chk1("rst_misalign", st_misalign, 1'b0);
    rst = 1'b0;
    q.delete();
    mis_q = 1'b0;

    tbl[0]  = vec(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[1]  = vec(1, 64'h8000_0003, 64'hAB, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[2]  = vec(0, 0, 0, 0, 0, 1, 64'h8000_0007, 1, 1, 1, 0, 0,
                  64'h8000_0000, 64'hABAB_ABAB_ABAB_ABAB, 8'h08);
    tbl[3]  = vec(0, 0, 0, 0, 1, 1, 64'h8000_0008, 1, 1, 0, 0, 0,
                  64'h8000_0000, 64'hABAB_ABAB_ABAB_ABAB, 8'h08);
    tbl[4]  = vec(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[5]  = vec(1, 64'h8000_0001, 64'h1234, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[6]  = vec(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[7]  = vec(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[8]  = vec(1, 64'h8000_0004, 64'h0123_4567_89AB_CDEF, 3, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[9]  = vec(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[10] = vec(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[11] = vec(1, 64'h8000_0010, 64'h1122_3344_5566_7788, 3, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[12] = vec(0, 0, 0, 0, 0, 1, 64'h8000_0017, 1, 1, 1, 0, 0,
                  64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    tbl[13] = vec(0, 0, 0, 0, 0, 1, 64'h8000_0018, 1, 1, 0, 0, 0,
                  64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    tbl[14] = vec(0, 0, 0, 0, 1, 1, 64'h8000_0010, 1, 1, 1, 0, 0,
                  64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    tbl[15] = vec(1, 64'h8000_0020, 64'hDEAD_BEEF_CAFE_F00D, 2, 1, 1, 64'h8000_0020,
                  1, 0, 0, 0, 1, 0, 0, 0);
    tbl[16] = vec(1, 64'h8000_0026, 64'h1234, 1, 1, 1, 64'h8000_0024, 1, 1, 1, 0, 0,
                  64'h8000_0020, 64'hCAFE_F00D_CAFE_F00D, 8'h0F);
    tbl[17] = vec(0, 0, 0, 0, 1, 0, 64'h8000_0020, 1, 1, 0, 0, 0,
                  64'h8000_0020, 64'h1234_1234_1234_1234, 8'hC0);
    tbl[18] = vec(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].ss, tbl[i].wr, tbl[i].lv, tbl[i].la);
      #1;
      chk1($sformatf("t%0d_ready", i), st_ready, tbl[i].rdy);
      chk1($sformatf("t%0d_wvalid", i), mem_wvalid, tbl[i].wv);
      chk1($sformatf("t%0d_ldhit", i), ld_hit, tbl[i].hit);
      chk1($sformatf("t%0d_misalign", i), st_misalign, tbl[i].mis);
      chk1($sformatf("t%0d_empty", i), empty, tbl[i].emp);
      if (tbl[i].wv) begin
        chk64($sformatf("t%0d_waddr", i), mem_waddr, tbl[i].waddr);
        chk64($sformatf("t%0d_wdata", i), mem_wdata, tbl[i].wdata);
        chk64($sformatf("t%0d_wmask", i), {56'h0, mem_wmask}, {56'h0, tbl[i].wmask});
      end
      @(posedge clk);
      #1;
    end

    // Fill with the write port stalled, try a fifth store, then drain in order.
    for (int i = 0; i < 4; i++)
      mcycle(1, 64'h100 + 64'(8 * i), 64'(i + 1), 2, 0, 0, 0);
    chk1("full_not_ready", st_ready, 1'b0);
    mcycle(1, 64'h200, 64'h55, 2, 0, 0, 0);
    mcycle(0, 0, 0, 0, 1, 0, 0);
    chk1("ready_after_pop", st_ready, 1'b1);
    for (int i = 0; i < 3; i++) mcycle(0, 0, 0, 0, 1, 0, 0);
    chk1("drained_empty", empty, 1'b1);

    // Two pending, then simultaneous push/pop long enough to wrap the pointers.
    mcycle(1, 64'h300, 64'hA0, 3, 0, 0, 0);
    mcycle(1, 64'h308, 64'hA1, 3, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      mcycle(1, 64'h400 + 64'(8 * i), 64'hB0 + 64'(i), 3, 1, 1, 64'h400);
    mcycle(0, 0, 0, 0, 1, 0, 0);
    mcycle(0, 0, 0, 0, 1, 0, 0);
    chk1("wrap_empty", empty, 1'b1);

    // Reset in the middle of a drain clears everything without a clock edge.
    for (int i = 0; i < 3; i++)
      mcycle(1, 64'h500 + 64'(8 * i), 64'hC0 + 64'(i), 3, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 64'h500);
    #1;
    chk1("pre_rst_hit", ld_hit, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mid_rst_wvalid", mem_wvalid, 1'b0);
    chk1("mid_rst_empty", empty, 1'b1);
    chk1("mid_rst_ready", st_ready, 1'b1);
    chk1("mid_rst_ldhit", ld_hit, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mis_q = 1'b0;
    for (int i = 0; i < 3; i++) mcycle(0, 0, 0, 0, 1, 1, 64'h508);

    // Randomized traffic on a small address window so hits and wraps are frequent.
    for (int i = 0; i < 400; i++) begin
      logic        r_sv, r_wr, r_lv;
      logic [1:0]  r_ss;
      logic [63:0] r_sa, r_sd, r_la;
      r_sv = 1'($urandom_range(0, 1));
      r_ss = 2'($urandom_range(0, 3));
      r_sa = 64'h8000_0000 + 64'(8 * $urandom_range(0, 5)) + 64'($urandom_range(0, 7));
      r_sd = {$urandom, $urandom};
      r_wr = ($urandom_range(0, 2) != 0);
      r_lv = 1'($urandom_range(0, 1));
      r_la = 64'h8000_0000 + 64'($urandom_range(0, 47));
      mcycle(r_sv, r_sa, r_sd, r_ss, r_wr, r_lv, r_la);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
